// File: rtl/bfly_stage_sched_if.sv
// Port bundle for bfly_stage_sched: frame alerts, error clear, butterfly controls, debug state.
// Optional BFLY_SCHED_STATS_EN adds the 16-bit frame_cnt field.
interface bfly_stage_sched_if #(
   parameter int TW_AW = 3
);
   // alert_in/alert_out are single-cycle pulses with no back-pressure: a pulse is
   // consumed on the edge that samples it, and there is no ready to wait for.
   logic             alert_in;
   logic             err_clr;
   logic             mux_sel;
   logic [TW_AW-1:0] tw_addr;
   logic             tw_valid;
   logic             busy;
   logic             alert_out;
   logic             frame_done;
   logic             overrun_err;
   logic [1:0]       dbg_state;
`ifdef BFLY_SCHED_STATS_EN
   logic [15:0]      frame_cnt;

   modport master (
      output alert_in, err_clr,
      input  mux_sel, tw_addr, tw_valid, busy, alert_out, frame_done, overrun_err,
             dbg_state, frame_cnt
   );
   modport slave (
      input  alert_in, err_clr,
      output mux_sel, tw_addr, tw_valid, busy, alert_out, frame_done, overrun_err,
             dbg_state, frame_cnt
   );
`else
   modport master (
      output alert_in, err_clr,
      input  mux_sel, tw_addr, tw_valid, busy, alert_out, frame_done, overrun_err,
             dbg_state
   );
   modport slave (
      input  alert_in, err_clr,
      output mux_sel, tw_addr, tw_valid, busy, alert_out, frame_done, overrun_err,
             dbg_state
   );
`endif
endinterface

// File: rtl/bfly_stage_sched.sv
// Radix-2 butterfly stage scheduler: ADD half then SUB half per frame alert.
// Optional BFLY_SCHED_STATS_EN adds a wrapping 16-bit completed-frame counter.
module bfly_stage_sched #(
   parameter int HALF_LEN  = 8,
   parameter int TW_AW     = $clog2(HALF_LEN),
   parameter int ALERT_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   bfly_stage_sched_if.slave bus
);
   localparam int CNT_W = $clog2(2 * HALF_LEN);
   localparam logic [CNT_W-1:0] ADD_LAST = CNT_W'(HALF_LEN - 1);
   localparam logic [CNT_W-1:0] SUB_LAST = CNT_W'(2 * HALF_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      SUB  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ALERT_LAT-1:0] alert_sr;
   logic             mux_sel_q, tw_valid_q, busy_q, frame_done_q, overrun_q;
   logic [TW_AW-1:0] tw_addr_q;
   logic             last_sub, overrun, first_add;

   assign last_sub  = (state_q == SUB) && (cnt_q == SUB_LAST);
   assign overrun   = bus.alert_in && (state_q != IDLE) && !last_sub;
   assign first_add = (state_q == ADD) && (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.alert_in) begin
               state_d = ADD;
               cnt_d   = '0;
            end
         end
         ADD: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == ADD_LAST) state_d = SUB;
         end
         SUB: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (last_sub) begin
               // A fresh alert exactly on the closing cycle chains straight into ADD.
               state_d = bus.alert_in ? ADD : IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from next-state values so they move on the same edge as state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         alert_sr     <= '0;
         mux_sel_q    <= 1'b0;
         tw_valid_q   <= 1'b0;
         tw_addr_q    <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mux_sel_q    <= (state_d == SUB);
         tw_valid_q   <= (state_d == SUB);
         tw_addr_q    <= (state_d == SUB) ? cnt_d[TW_AW-1:0] : '0;
         busy_q       <= (state_d != IDLE);
         frame_done_q <= (state_d == SUB) && (cnt_d == SUB_LAST);
         overrun_q    <= overrun || (overrun_q && !bus.err_clr);
         alert_sr[0]  <= first_add;
         for (int i = 1; i < ALERT_LAT; i++) alert_sr[i] <= alert_sr[i-1];
      end
   end

   assign bus.mux_sel     = mux_sel_q;
   assign bus.tw_valid    = tw_valid_q;
   assign bus.tw_addr     = tw_addr_q;
   assign bus.busy        = busy_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.overrun_err = overrun_q;
   assign bus.alert_out   = alert_sr[ALERT_LAT-1];
   assign bus.dbg_state   = state_q;

`ifdef BFLY_SCHED_STATS_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) frame_cnt_q <= '0;
      else if (frame_done_q) frame_cnt_q <= frame_cnt_q + 16'd1;
   end

   assign bus.frame_cnt = frame_cnt_q;
`endif
endmodule
